// File: rtl/ddr3_wr_ctrl.sv
// ddr3_wr_ctrl: burst write controller from the 256-bit write-data FIFO to
// the MIG app interface. It waits for calibration and a full burst of FIFO
// words, then issues BURST_LEN write commands at sequential addresses and
// streams the matching FIFO words. The command and data channels advance
// independently.
// Optional macro DDR_WR_WRAP_EN: when defined, the base address wraps to 0 at
// ADDR_LIMIT and writing continues. When undefined, the block parks in HALT
// after the burst that ends at ADDR_LIMIT, with wr_done held high. Only reset
// leaves HALT.
module ddr3_wr_ctrl #(
    parameter int                ADDR_W     = 28,
    parameter int                CNT_W      = 10,
    parameter int                BURST_LEN  = 64,
    parameter int                ADDR_STEP  = 8,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT = 28'h800_0000
) (
    input  logic              ui_clk,
    input  logic              rst,
    input  logic              init_calib_complete,
    input  logic [CNT_W-1:0]  fifo_rd_count,
    input  logic [255:0]      fifo_dout,
    output logic              fifo_rd_en,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    input  logic              app_rdy,
    output logic [ADDR_W-1:0] app_addr,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    output logic [255:0]      app_wdf_data,
    output logic [31:0]       app_wdf_mask,
    input  logic              app_wdf_rdy,
    output logic              wr_busy,
    output logic              wr_done
);

    localparam int                CW           = $clog2(BURST_LEN) + 1;
    localparam logic [CW-1:0]     BL_C         = CW'(BURST_LEN);
    localparam logic [CNT_W-1:0]  FILL_C       = CNT_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] STEP_C       = ADDR_W'(ADDR_STEP);
    localparam logic [ADDR_W-1:0] BURST_SPAN_C = ADDR_W'(BURST_LEN * ADDR_STEP);

    typedef enum logic [2:0] {
        IDLE_S  = 3'd0,
        WAIT_S  = 3'd1,
        BURST_S = 3'd2,
        DONE_S  = 3'd3,
        HALT_S  = 3'd4
    } state_t;

    state_t              state_r;
    logic [CW-1:0]       cmd_cnt_r;
    logic [CW-1:0]       dat_cnt_r;
    logic [ADDR_W-1:0]   cur_addr_r;
    logic [ADDR_W-1:0]   base_addr_r;
    logic                app_en_r;
    logic                wdf_wren_r;
    logic                wr_busy_r;
    logic                wr_done_r;

    logic                cmd_acc_s;
    logic                dat_acc_s;
    logic [CW-1:0]       cmd_cnt_nxt_s;
    logic [CW-1:0]       dat_cnt_nxt_s;
    logic                burst_end_s;
    logic [ADDR_W-1:0]   base_nxt_s;
    logic                base_at_limit_s;

    // Counter advance: add one when the channel handshake completes.
    function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] cnt, input logic acc);
        return cnt + {{(CW-1){1'b0}}, acc};
    endfunction

    // The handshakes feed only next-state logic and the FIFO pop. The valids
    // come straight from registers.
    assign cmd_acc_s       = app_en_r & app_rdy;
    assign dat_acc_s       = wdf_wren_r & app_wdf_rdy;
    assign cmd_cnt_nxt_s   = cnt_inc(cmd_cnt_r, cmd_acc_s);
    assign dat_cnt_nxt_s   = cnt_inc(dat_cnt_r, dat_acc_s);
    // The burst ends when both channels finish. This includes the case where
    // the last command and the last data word are accepted on the same edge.
    assign burst_end_s     = (cmd_cnt_nxt_s == BL_C) && (dat_cnt_nxt_s == BL_C);
    assign base_nxt_s      = base_addr_r + BURST_SPAN_C;
    assign base_at_limit_s = (base_nxt_s == ADDR_LIMIT);

    assign fifo_rd_en   = dat_acc_s;
    assign app_cmd      = 3'b000;
    assign app_en       = app_en_r;
    assign app_addr     = cur_addr_r;
    assign app_wdf_wren = wdf_wren_r;
    assign app_wdf_end  = wdf_wren_r;
    assign app_wdf_data = fifo_dout;
    assign app_wdf_mask = 32'h0000_0000;
    assign wr_busy      = wr_busy_r;
    assign wr_done      = wr_done_r;

    // Controller FSM: state, burst counters, addresses and registered outputs.
    always_ff @(posedge ui_clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE_S;
            cmd_cnt_r   <= {CW{1'b0}};
            dat_cnt_r   <= {CW{1'b0}};
            cur_addr_r  <= {ADDR_W{1'b0}};
            base_addr_r <= {ADDR_W{1'b0}};
            app_en_r    <= 1'b0;
            wdf_wren_r  <= 1'b0;
            wr_busy_r   <= 1'b0;
            wr_done_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE_S: begin
                    app_en_r   <= 1'b0;
                    wdf_wren_r <= 1'b0;
                    wr_busy_r  <= 1'b0;
                    wr_done_r  <= 1'b0;
                    if (init_calib_complete) begin
                        state_r <= WAIT_S;
                    end else begin
                        state_r <= IDLE_S;
                    end
                end
                WAIT_S: begin
                    wr_done_r <= 1'b0;
                    if (init_calib_complete && (fifo_rd_count >= FILL_C)) begin
                        state_r    <= BURST_S;
                        cmd_cnt_r  <= {CW{1'b0}};
                        dat_cnt_r  <= {CW{1'b0}};
                        cur_addr_r <= base_addr_r;
                        app_en_r   <= 1'b1;
                        wdf_wren_r <= 1'b1;
                        wr_busy_r  <= 1'b1;
                    end else begin
                        state_r    <= WAIT_S;
                        app_en_r   <= 1'b0;
                        wdf_wren_r <= 1'b0;
                        wr_busy_r  <= 1'b0;
                    end
                end
                BURST_S: begin
                    cmd_cnt_r  <= cmd_cnt_nxt_s;
                    dat_cnt_r  <= dat_cnt_nxt_s;
                    app_en_r   <= (cmd_cnt_nxt_s < BL_C);
                    wdf_wren_r <= (dat_cnt_nxt_s < BL_C);
                    wr_busy_r  <= 1'b1;
                    if (cmd_acc_s) begin
                        cur_addr_r <= cur_addr_r + STEP_C;
                    end else begin
                        cur_addr_r <= cur_addr_r;
                    end
                    if (burst_end_s) begin
                        state_r   <= DONE_S;
                        wr_done_r <= 1'b1;
                    end else begin
                        state_r   <= BURST_S;
                        wr_done_r <= 1'b0;
                    end
                end
                DONE_S: begin
                    app_en_r   <= 1'b0;
                    wdf_wren_r <= 1'b0;
                    wr_busy_r  <= 1'b0;
                    if (base_at_limit_s) begin
                        base_addr_r <= {ADDR_W{1'b0}};
`ifdef DDR_WR_WRAP_EN
                        state_r     <= WAIT_S;
                        wr_done_r   <= 1'b0;
`else
                        state_r     <= HALT_S;
                        wr_done_r   <= 1'b1;
`endif
                    end else begin
                        base_addr_r <= base_nxt_s;
                        state_r     <= WAIT_S;
                        wr_done_r   <= 1'b0;
                    end
                end
                HALT_S: begin
                    state_r    <= HALT_S;
                    app_en_r   <= 1'b0;
                    wdf_wren_r <= 1'b0;
                    wr_busy_r  <= 1'b0;
                    wr_done_r  <= 1'b1;
                end
                default: begin
                    state_r    <= IDLE_S;
                    app_en_r   <= 1'b0;
                    wdf_wren_r <= 1'b0;
                    wr_busy_r  <= 1'b0;
                    wr_done_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_wr_ctrl.sv
// tb_ddr3_wr_ctrl: scenario-driven bench for ddr3_wr_ctrl. The DUT uses a
// 1024-address region, so bases run 0, 512 and then either wrap or halt,
// depending on DDR_WR_WRAP_EN. A bench-side FIFO model supplies data words.
// Expected addresses and words are queued when a burst is started and are
// popped as the DUT handshakes them.
`timescale 1ns/1ps
module tb_ddr3_wr_ctrl;
    localparam int         BL    = 64;
    localparam int         STEP  = 8;
    localparam logic [27:0] LIMIT = 28'd1024;

    logic         ui_clk = 1'b0;
    logic         rst;
    logic         init_calib_complete;
    logic [9:0]   fifo_rd_count;
    logic [255:0] fifo_dout;
    logic         fifo_rd_en;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy;
    logic [27:0]  app_addr;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic [255:0] app_wdf_data;
    logic [31:0]  app_wdf_mask;
    logic         app_wdf_rdy;
    logic         wr_busy;
    logic         wr_done;

    always #5 ui_clk = ~ui_clk;

    ddr3_wr_ctrl #(
        .ADDR_W(28), .CNT_W(10), .BURST_LEN(BL), .ADDR_STEP(STEP), .ADDR_LIMIT(LIMIT)
    ) dut (
        .ui_clk(ui_clk), .rst(rst), .init_calib_complete(init_calib_complete),
        .fifo_rd_count(fifo_rd_count), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
        .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy), .app_addr(app_addr),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_data(app_wdf_data),
        .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
        .wr_busy(wr_busy), .wr_done(wr_done)
    );

    int           total = 0;
    int           bad = 0;
    logic [27:0]  exp_addr_q[$];
    logic [255:0] exp_data_q[$];
    int           fifo_idx = 0;
    logic         pop_pending = 1'b0;
    int           cmd_seen = 0;
    int           dat_seen = 0;
    int           en_cycles = 0;
    int           max_lag = 0;
    logic         just_completed = 1'b0;
    logic         halted_exp = 1'b0;
    logic         done_hit = 1'b0;
    logic         stall_prev = 1'b0;
    logic [27:0]  addr_prev = 28'd0;

    function automatic logic [255:0] word(input int idx);
        logic [255:0] w;
        for (int k = 0; k < 8; k++) w[k*32 +: 32] = 32'(idx * 8 + k) * 32'h9E37_79B1;
        return w;
    endfunction

    // Sample one cycle at the falling edge. Check handshakes against the
    // scoreboard, then apply any FIFO pop after the rising edge.
    task automatic observe();
        logic exp_done;
        logic acc_any;
        logic [27:0]  ea;
        logic [255:0] ed;
        exp_done = just_completed | halted_exp;
        done_hit = just_completed;
        acc_any = 1'b0;
        total++;
        if (wr_done !== exp_done) begin
            bad++; $display("FAIL wr_done: got %b want %b at %0t", wr_done, exp_done, $time);
        end
        if (done_hit && !halted_exp) begin
            total++;
            if (wr_busy !== 1'b1) begin bad++; $display("FAIL busy_in_done: got %b want 1", wr_busy); end
        end
        total++;
        if (app_wdf_end !== app_wdf_wren) begin
            bad++; $display("FAIL wdf_end: got %b want %b", app_wdf_end, app_wdf_wren);
        end
        total++;
        if (app_cmd !== 3'b000 || app_wdf_mask !== 32'h0) begin
            bad++; $display("FAIL cmd_mask: got %b/%h want 000/0", app_cmd, app_wdf_mask);
        end
        total++;
        if (fifo_rd_en !== (app_wdf_wren & app_wdf_rdy)) begin
            bad++; $display("FAIL fifo_rd_en: got %b want %b", fifo_rd_en, app_wdf_wren & app_wdf_rdy);
        end
        if (stall_prev) begin
            total++;
            if (app_addr !== addr_prev) begin
                bad++; $display("FAIL addr_stable: got %h want %h", app_addr, addr_prev);
            end
        end
        stall_prev = (app_en === 1'b1) && (app_rdy === 1'b0);
        addr_prev = app_addr;
        if (app_en === 1'b1) en_cycles++;
        just_completed = 1'b0;
        if (app_en === 1'b1 && app_rdy === 1'b1) begin
            acc_any = 1'b1;
            cmd_seen++;
            total++;
            if (exp_addr_q.size() == 0) begin
                bad++; $display("FAIL cmd_extra: got addr %h want no command", app_addr);
            end else begin
                ea = exp_addr_q.pop_front();
                if (app_addr !== ea) begin bad++; $display("FAIL cmd_addr: got %h want %h", app_addr, ea); end
            end
        end
        if (app_wdf_wren === 1'b1 && app_wdf_rdy === 1'b1) begin
            acc_any = 1'b1;
            dat_seen++;
            pop_pending = 1'b1;
            total++;
            if (exp_data_q.size() == 0) begin
                bad++; $display("FAIL dat_extra: got %h want no data", app_wdf_data[31:0]);
            end else begin
                ed = exp_data_q.pop_front();
                if (app_wdf_data !== ed) begin
                    bad++; $display("FAIL dat_word: got %h want %h", app_wdf_data[63:0], ed[63:0]);
                end
            end
        end
        if (acc_any) begin
            total++;
            if (wr_busy !== 1'b1) begin bad++; $display("FAIL busy_burst: got %b want 1", wr_busy); end
            if (cmd_seen == BL && dat_seen == BL) just_completed = 1'b1;
        end
        if (cmd_seen - dat_seen > max_lag) max_lag = cmd_seen - dat_seen;
    endtask

    task automatic step();
        @(negedge ui_clk);
        observe();
        @(posedge ui_clk);
        #1;
        if (pop_pending) begin
            fifo_idx++;
            fifo_dout = word(fifo_idx);
            pop_pending = 1'b0;
        end
    endtask

    task automatic clear_bench();
        exp_addr_q.delete();
        exp_data_q.delete();
        just_completed = 1'b0;
        halted_exp = 1'b0;
        stall_prev = 1'b0;
        cmd_seen = 0;
        dat_seen = 0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        clear_bench();
        for (int i = 0; i < cycles; i++) step();
        rst = 1'b1;
    endtask

    task automatic push_expected(input logic [27:0] base);
        cmd_seen = 0; dat_seen = 0; en_cycles = 0; max_lag = 0;
        for (int i = 0; i < BL; i++) begin
            exp_addr_q.push_back(base + 28'(i * STEP));
            exp_data_q.push_back(word(fifo_idx + i));
        end
    endtask

    // Run one burst to its wr_done sample. first_en is the index of the
    // first cycle that showed app_en.
    task automatic run_burst(input logic [27:0] base, input bit bp, output int first_en);
        int  pre_en;
        bit  finished;
        first_en = -1;
        finished = 1'b0;
        push_expected(base);
        for (int c = 0; c < 1000; c++) begin
            if (bp) begin
                app_rdy = (c % 2 == 0);
                app_wdf_rdy = (c >= 20);
            end else begin
                app_rdy = 1'b1;
                app_wdf_rdy = 1'b1;
            end
            pre_en = en_cycles;
            step();
            if (first_en < 0 && en_cycles > pre_en) first_en = c;
            if (done_hit) begin
                finished = 1'b1;
                break;
            end
        end
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;
        total++;
        if (!finished) begin bad++; $display("FAIL burst_timeout: got no wr_done want done, base %h", base); end
        total++;
        if (cmd_seen != BL || dat_seen != BL) begin
            bad++; $display("FAIL burst_counts: got cmd=%0d dat=%0d want %0d", cmd_seen, dat_seen, BL);
        end
        total++;
        if (exp_addr_q.size() != 0 || exp_data_q.size() != 0) begin
            bad++; $display("FAIL burst_left: got %0d/%0d queued want 0", exp_addr_q.size(), exp_data_q.size());
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        total++;
        if (app_en !== 1'b0 || app_wdf_wren !== 1'b0 || fifo_rd_en !== 1'b0 || wr_busy !== 1'b0 ||
            wr_done !== 1'b0 || app_addr !== 28'd0 || app_wdf_end !== 1'b0) begin
            bad++;
            $display("FAIL %s: got en=%b wren=%b rd=%b busy=%b done=%b addr=%h want all 0",
                     tag, app_en, app_wdf_wren, fifo_rd_en, wr_busy, wr_done, app_addr);
        end
    endtask

    task automatic test_reset();
        do_reset(100);
        check_outputs_zero("reset_state");
        init_calib_complete = 1'b0;
        fifo_rd_count = 10'd100;
        for (int i = 0; i < 20; i++) begin
            step();
            check_outputs_zero("idle_no_calib");
        end
    endtask

    task automatic test_single_burst();
        int fe;
        init_calib_complete = 1'b1;
        fifo_rd_count = 10'd64;
        run_burst(28'd0, 1'b0, fe);
        total++;
        if (fe != 2) begin bad++; $display("FAIL single_first_en: got %0d want 2", fe); end
        total++;
        if (en_cycles != BL) begin bad++; $display("FAIL single_en_cycles: got %0d want %0d", en_cycles, BL); end
    endtask

    task automatic test_insufficient_data();
        int fe;
        fifo_rd_count = 10'd63;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (app_en !== 1'b0) begin bad++; $display("FAIL short_fifo_en: got %b want 0", app_en); end
        end
        fifo_rd_count = 10'd64;
        run_burst(28'd512, 1'b0, fe);
        total++;
        if (fe != 1) begin bad++; $display("FAIL short_first_en: got %0d want 1", fe); end
    endtask

    task automatic test_wrap();
        int fe;
`ifdef DDR_WR_WRAP_EN
        run_burst(28'd0, 1'b0, fe);
        total++;
        if (fe != 1) begin bad++; $display("FAIL wrap_first_en: got %0d want 1", fe); end
`else
        fe = 0;
        halted_exp = 1'b1;
        for (int i = 0; i < 10 + fe; i++) begin
            step();
            total++;
            if (app_en !== 1'b0 || wr_busy !== 1'b0 || app_wdf_wren !== 1'b0) begin
                bad++; $display("FAIL halt: got en=%b busy=%b wren=%b want 0", app_en, wr_busy, app_wdf_wren);
            end
        end
`endif
    endtask

    task automatic test_backpressure();
        int fe;
        do_reset(3);
        run_burst(28'd0, 1'b1, fe);
        total++;
        if (max_lag <= 0) begin bad++; $display("FAIL bp_lag: got lag %0d want >0", max_lag); end
    endtask

    task automatic test_reset_mid_burst();
        int fe;
        bit reached;
        reached = 1'b0;
        push_expected(28'd512);
        for (int c = 0; c < 300; c++) begin
            step();
            if (cmd_seen >= 30) begin
                reached = 1'b1;
                break;
            end
        end
        total++;
        if (!reached) begin bad++; $display("FAIL mid_timeout: got %0d accepts want 30", cmd_seen); end
        #2;
        rst = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        clear_bench();
        step();
        step();
        rst = 1'b1;
        run_burst(28'd0, 1'b0, fe);
        total++;
        if (fe != 2) begin bad++; $display("FAIL mid_restart_first_en: got %0d want 2", fe); end
    endtask

    initial begin
        rst = 1'b0;
        init_calib_complete = 1'b0;
        fifo_rd_count = 10'd100;
        fifo_dout = word(0);
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;
        #1;
        test_reset();
        test_single_burst();
        test_insufficient_data();
        test_wrap();
        test_backpressure();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish before 2ms");
        $fatal(1, "watchdog");
    end

endmodule
